// File: rtl/twenty_to_five_pkg.sv
// Shared word-muxing constants for the narrow/wide lane converters.
// The 5-to-20 accumulator and the 20-to-5 splitter both import this package.
// This keeps the two ends of the round trip in agreement on group size and order.
package twenty_to_five_pkg;

    localparam int WORDS_NARROW     = 5;
    localparam int WORDS_WIDE       = 20;
    localparam int GROUPS           = WORDS_WIDE / WORDS_NARROW;
    localparam int WORD_LEN_DEFAULT = 66;

    // Width of the outstanding-group counter (must hold 0..GROUPS).
    localparam int REMAIN_W = 3;

    // Load value for the counter when a fresh wide block is accepted.
    function automatic logic [REMAIN_W-1:0] full_count();
        return REMAIN_W'(GROUPS);
    endfunction

endpackage

// File: rtl/twenty_to_five.sv
// twenty_to_five: splits one 20-word block into four consecutive 5-word groups.
// The least significant group (words 0-4) is emitted first.
//
// Ports:
//   clk         single clock, rising edge
//   arst        asynchronous active-high reset
//   din         20-word input block, word k at [(k+1)*WORD_LEN-1 : k*WORD_LEN]
//   din_valid   din holds a block
//   din_ready   block accepted on an edge where din_valid & din_ready
//   dout        current 5-word group, group word 0 in the low bits
//   dout_valid  dout holds a group
//   dout_ready  group consumed on an edge where dout_valid & dout_ready
//
// din_ready depends combinationally on dout_ready. This lets a new block load
// on the same edge that the last group of the previous block leaves, so there
// is no bubble between blocks.
module twenty_to_five
    import twenty_to_five_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEFAULT
)
(
    input  logic                             clk,
    input  logic                             arst,
    input  logic [WORDS_WIDE*WORD_LEN-1:0]   din,
    input  logic                             din_valid,
    output logic                             din_ready,
    output logic [WORDS_NARROW*WORD_LEN-1:0] dout,
    output logic                             dout_valid,
    input  logic                             dout_ready
);

    localparam int NW = WORDS_NARROW * WORD_LEN;
    localparam int WW = WORDS_WIDE * WORD_LEN;

    logic [WW-1:0]       buf_r;
    logic [REMAIN_W-1:0] remain_r;
    logic                accept_s;
    logic                consume_s;

    // Output view of the shift register and the handshake decode.
    always_comb begin
        dout       = buf_r[NW-1:0];
        dout_valid = (remain_r != {REMAIN_W{1'b0}});
        din_ready  = (remain_r == {REMAIN_W{1'b0}}) ||
                     ((remain_r == REMAIN_W'(1)) && dout_ready);
        accept_s   = din_valid && din_ready;
        consume_s  = dout_valid && dout_ready;
    end

    // Block register and group counter. A load takes priority over a shift, so
    // the last group and the next block can be exchanged on the same edge. The
    // shift pulls zeros into the top so that a drained buffer reads back as zero.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            buf_r    <= {WW{1'b0}};
            remain_r <= {REMAIN_W{1'b0}};
        end else if (accept_s) begin
            buf_r    <= din;
            remain_r <= full_count();
        end else if (consume_s) begin
            buf_r    <= {{NW{1'b0}}, buf_r[WW-1:NW]};
            remain_r <= remain_r - REMAIN_W'(1);
        end else begin
            buf_r    <= buf_r;
            remain_r <= remain_r;
        end
    end

endmodule

// File: tb/tb_twenty_to_five.sv
module tb_twenty_to_five;

    localparam int W  = 8;
    localparam int BW = 20 * W;
    localparam int GW = 5 * W;

    logic          clk;
    logic          arst;
    logic [BW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [GW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;

    int tests = 0;
    int fails = 0;

    // Scoreboard of expected groups, and the word streams used by the loopback run.
    logic [GW-1:0] sb_q[$];
    logic [W-1:0]  in_q[$];
    logic [W-1:0]  got_q[$];
    bit            loop_en  = 1'b0;
    bit            rand_rdy = 1'b0;

    twenty_to_five #(.WORD_LEN(W)) dut (
        .clk        (clk),
        .arst       (arst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Block whose word k equals base+k.
    function automatic logic [BW-1:0] mk(input logic [7:0] base);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < 20; k++) r[k*W +: W] = base + 8'(k);
        return r;
    endfunction

    // Present a block until it is accepted; returns at posedge+1 of the accepting edge.
    task automatic drive_block(input logic [BW-1:0] blk);
        bit acc;
        din       = blk;
        din_valid = 1'b1;
        acc       = 1'b0;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check(1'b0, "accept_timeout", '0, 1);
        din_valid = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Random downstream backpressure during the loopback run.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) dout_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: an abstract model of the outstanding-group count.
    // The model predicts valid and ready, and expected groups are pushed when a block is accepted.
    // Every group the DUT hands off is checked against the front of the queue.
    initial begin
        int            rem_m;
        bit            exp_rdy;
        bit            prev_valid;
        bit            prev_ready;
        logic [GW-1:0] prev_dout;
        logic [GW-1:0] e;
        rem_m      = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_dout  = '0;
        forever begin
            @(negedge clk);
            if (arst) begin
                sb_q.delete();
                rem_m      = 0;
                prev_valid = 1'b0;
                check(!dout_valid, "rst_valid", BW'(dout_valid), 0);
                check(dout == '0, "rst_dout", BW'(dout), 0);
            end else begin
                exp_rdy = (rem_m == 0) || (rem_m == 1 && dout_ready);
                check(dout_valid == (rem_m != 0), "dout_valid", BW'(dout_valid), BW'(rem_m != 0));
                check(din_ready == exp_rdy, "din_ready", BW'(din_ready), BW'(exp_rdy));
                if (!dout_valid) check(dout == '0, "idle_zero", BW'(dout), 0);
                if (prev_valid && !prev_ready && dout_valid)
                    check(dout == prev_dout, "stall_stable", BW'(dout), BW'(prev_dout));
                if (dout_valid && dout_ready) begin
                    if (sb_q.size() == 0) begin
                        check(1'b0, "unexpected_group", BW'(dout), 0);
                    end else begin
                        e = sb_q.pop_front();
                        check(dout == e, "group", BW'(dout), BW'(e));
                    end
                    if (loop_en) for (int k = 0; k < 5; k++) got_q.push_back(dout[k*W +: W]);
                end
                if (din_valid && exp_rdy) begin
                    rem_m = 4;
                    for (int g = 0; g < 4; g++) sb_q.push_back(din[g*GW +: GW]);
                end else if (rem_m != 0 && dout_ready) begin
                    rem_m = rem_m - 1;
                end
                prev_valid = dout_valid;
                prev_ready = dout_ready;
                prev_dout  = dout;
            end
        end
    end

    initial begin
        logic [BW-1:0] blk;
        logic [W-1:0]  wd;
        int            n;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        arst       = 1'b0;
        #1;
        arst = 1'b1;
        cyc(3);
        arst = 1'b0;
        #1;
        check(dout == '0 && !dout_valid && din_ready, "reset_idle",
              {dout, 2'(0), dout_valid, din_ready}, {GW'(0), 2'(0), 1'b0, 1'b1});
        cyc(4);

        // Single block, full-rate drain.
        drive_block(mk(8'h00));
        check(dout == 40'h04_03_02_01_00, "single_g0", BW'(dout), BW'(40'h04_03_02_01_00));
        cyc(3);
        check(dout == 40'h13_12_11_10_0F, "single_g3", BW'(dout), BW'(40'h13_12_11_10_0F));
        cyc(1);
        check(!dout_valid && dout == '0, "single_drain", BW'({dout_valid, dout}), 0);

        // Back-to-back blocks with no idle cycle between them.
        drive_block(mk(8'h00));
        drive_block(mk(8'h20));
        check(dout == 40'h24_23_22_21_20, "b2b_g0", BW'(dout), BW'(40'h24_23_22_21_20));
        cyc(5);

        // Backpressure while group 1 is shown.
        drive_block(mk(8'h40));
        cyc(1);
        dout_ready = 1'b0;
        cyc(5);
        check(dout == 40'h49_48_47_46_45 && dout_valid, "bp_hold", BW'(dout), BW'(40'h49_48_47_46_45));
        check(!din_ready, "bp_din_ready", BW'(din_ready), 0);
        dout_ready = 1'b1;
        cyc(2);
        dout_ready = 1'b0;
        #1;
        check(!din_ready, "last_stalled", BW'(din_ready), 0);
        dout_ready = 1'b1;
        #1;
        check(din_ready, "last_comb_ready", BW'(din_ready), 1);
        cyc(3);

        // Reset in the middle of a block discards its remaining groups.
        drive_block(mk(8'h60));
        cyc(1);
        arst = 1'b1;
        #1;
        check(!dout_valid && dout == '0, "midrst_clear", BW'({dout_valid, dout}), 0);
        cyc(2);
        arst = 1'b0;
        cyc(1);
        drive_block(mk(8'h80));
        check(dout == 40'h84_83_82_81_80, "after_rst_g0", BW'(dout), BW'(40'h84_83_82_81_80));
        cyc(5);

        // Loopback: 250 random blocks (1000 groups), random gaps and backpressure.
        loop_en  = 1'b1;
        rand_rdy = 1'b1;
        for (int b = 0; b < 250; b++) begin
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                din = {$urandom, $urandom, $urandom, $urandom, $urandom};
                cyc(1);
            end
            for (int k = 0; k < 20; k++) begin
                wd = W'($urandom);
                blk[k*W +: W] = wd;
                in_q.push_back(wd);
            end
            drive_block(blk);
        end
        n = 0;
        while ((sb_q.size() != 0 || dout_valid) && n < 3000) begin
            cyc(1);
            n++;
        end
        if (n >= 3000) check(1'b0, "drain_timeout", BW'(sb_q.size()), 0);
        rand_rdy   = 1'b0;
        dout_ready = 1'b1;
        cyc(2);
        loop_en = 1'b0;
        check(got_q.size() == in_q.size(), "loop_count", BW'(got_q.size()), BW'(in_q.size()));
        for (int i = 0; i < in_q.size() && i < got_q.size(); i += 5) begin
            check(got_q[i] == in_q[i] && got_q[i+1] == in_q[i+1] && got_q[i+2] == in_q[i+2] &&
                  got_q[i+3] == in_q[i+3] && got_q[i+4] == in_q[i+4], "loop_words",
                  BW'({got_q[i+4], got_q[i+3], got_q[i+2], got_q[i+1], got_q[i]}),
                  BW'({in_q[i+4], in_q[i+3], in_q[i+2], in_q[i+1], in_q[i]}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
